psr_cond_unit: RTL and testbench

- Processor status stage directly downstream of the 16-bit ALU.
- Holds the architectural flags {N,Z,F,L,C} and captures the ALU flag outputs on flag-writing instructions.
- Evaluates the 4-bit branch/jump condition field for the controller.
- Provides a small PSR save stack for interrupt entry (push) and return (pop), plus direct PSR write (LPR).

---
 rtl/psr_cond_unit.sv | 113 +++++++++++
 tb/tb_psr_cond_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/psr_cond_unit.sv
// Processor status register with branch-condition evaluation and a LIFO PSR
// save stack for interrupt entry/return. Flags are packed {N,Z,F,L,C}.
module psr_cond_unit #(
  parameter int STACK_DEPTH = 4,
  parameter bit BYPASS      = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [4:0]                     alu_flags,
  input  logic                           flag_we,
  input  logic                           psr_wr,
  input  logic [4:0]                     psr_wdata,
  input  logic                           push,
  input  logic                           pop,
  input  logic [3:0]                     cond,
  output logic [4:0]                     psr,
  output logic                           cond_true,
  output logic [$clog2(STACK_DEPTH):0]   stack_count,
  output logic                           stack_full,
  output logic                           stack_empty,
  output logic                           ovf_err,
  output logic                           unf_err,
  output logic                           proto_err
);

  localparam int CNT_W = $clog2(STACK_DEPTH) + 1;
  localparam int IDX_W = CNT_W - 1;

  function automatic logic eval_cond(input logic [3:0] code, input logic [4:0] f);
    logic n, z, fl, l, c, r;
    {n, z, fl, l, c} = f;
    case (code)
      4'h0:    r = z;
      4'h1:    r = !z;
      4'h2:    r = c;
      4'h3:    r = !c;
      4'h4:    r = l;
      4'h5:    r = !l;
      4'h6:    r = n;
      4'h7:    r = !n;
      4'h8:    r = fl;
      4'h9:    r = !fl;
      4'ha:    r = !l && !z;
      4'hb:    r = l || z;
      4'hc:    r = !n && !z;
      4'hd:    r = n || z;
      4'he:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [4:0]       stack_mem [STACK_DEPTH];
  logic [4:0]       cond_src;
  logic [4:0]       psr_next;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;
  logic             both_req;
  logic             do_push;
  logic             do_pop;

  assign stack_full  = (stack_count == CNT_W'(STACK_DEPTH));
  assign stack_empty = (stack_count == '0);

  assign both_req = push && pop;
  assign do_push  = push && !pop && !stack_full;
  assign do_pop   = pop && !push && !stack_empty;

  // When full the low index bits wrap to zero, so subtracting one still lands on DEPTH-1.
  assign wr_idx  = stack_count[IDX_W-1:0];
  assign top_idx = stack_count[IDX_W-1:0] - IDX_W'(1);

  // Bypass looks only at direct/ALU writes; a pending pop never feeds the condition.
  always_comb begin
    cond_src = psr;
    if (BYPASS) begin
      if (psr_wr)       cond_src = psr_wdata;
      else if (flag_we) cond_src = alu_flags;
    end
    cond_true = eval_cond(cond, cond_src);
  end

  always_comb begin
    psr_next = psr;
    if (do_pop)       psr_next = stack_mem[top_idx];
    else if (psr_wr)  psr_next = psr_wdata;
    else if (flag_we) psr_next = alu_flags;
  end

  // ---- register stage: architectural flags and stack control
  always_ff @(posedge clk) begin
    if (reset) begin
      psr         <= '0;
      stack_count <= '0;
      ovf_err     <= 1'b0;
      unf_err     <= 1'b0;
      proto_err   <= 1'b0;
    end else begin
      psr       <= psr_next;
      proto_err <= both_req;
      if (do_push)      stack_count <= stack_count + CNT_W'(1);
      else if (do_pop)  stack_count <= stack_count - CNT_W'(1);
      if (push && !pop && stack_full)  ovf_err <= 1'b1;
      if (pop && !push && stack_empty) unf_err <= 1'b1;
    end
  end

  // Stack storage keeps the pre-update PSR; contents are meaningless after reset.
  always_ff @(posedge clk) begin
    if (do_push) stack_mem[wr_idx] <= psr;
  end

endmodule

// File: tb/tb_psr_cond_unit.sv
// Scoreboard bench for psr_cond_unit: a behavioural model queues the expected
// condition result and post-edge state for every driven cycle.
module tb_psr_cond_unit;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef logic [18:0] stim_t;  // {rst, fw, af[5], wr, wd[5], pu, po, cd[4]}

  logic       clk = 1'b0;
  logic       reset, flag_we, psr_wr, push, pop;
  logic [4:0] alu_flags, psr_wdata;
  logic [3:0] cond;
  logic [4:0] psr;
  logic       cond_true, stack_full, stack_empty, ovf_err, unf_err, proto_err;
  logic [CW-1:0] stack_count;
  logic [12:0] obs;

  int n_checks = 0;
  int n_fail   = 0;

  logic [4:0]  m_psr = 5'b0;
  logic [4:0]  m_stk[$];
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;
  logic        cond_q[$];
  logic [12:0] state_q[$];

  always #5 clk = ~clk;

  psr_cond_unit #(.STACK_DEPTH(DEPTH), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .alu_flags(alu_flags), .flag_we(flag_we),
    .psr_wr(psr_wr), .psr_wdata(psr_wdata), .push(push), .pop(pop),
    .cond(cond), .psr(psr), .cond_true(cond_true), .stack_count(stack_count),
    .stack_full(stack_full), .stack_empty(stack_empty), .ovf_err(ovf_err),
    .unf_err(unf_err), .proto_err(proto_err)
  );

  assign obs = {psr, stack_count, stack_full, stack_empty, ovf_err, unf_err, proto_err};

  function automatic stim_t st(input logic rst, input logic fw, input logic [4:0] af,
                               input logic wr, input logic [4:0] wd,
                               input logic pu, input logic po, input logic [3:0] cd);
    return {rst, fw, af, wr, wd, pu, po, cd};
  endfunction

  function automatic logic ref_cond(input logic [3:0] c, input logic [4:0] f);
    logic n, z, fl, l, cy;
    n = f[4]; z = f[3]; fl = f[2]; l = f[1]; cy = f[0];
    case (c)
      4'h0: return z;        4'h1: return ~z;
      4'h2: return cy;       4'h3: return ~cy;
      4'h4: return l;        4'h5: return ~l;
      4'h6: return n;        4'h7: return ~n;
      4'h8: return fl;       4'h9: return ~fl;
      4'ha: return ~(l | z); 4'hb: return l | z;
      4'hc: return ~(n | z); 4'hd: return n | z;
      4'he: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle's inputs, queue the model's expectations, and move to mid-cycle.
  task automatic apply(input stim_t s);
    logic rst, fw, wr, pu, po, pr;
    logic [4:0] af, wd, src, nxt;
    logic [3:0] cd;
    int cnt;
    {rst, fw, af, wr, wd, pu, po, cd} = s;
    reset = rst; flag_we = fw; alu_flags = af; psr_wr = wr; psr_wdata = wd;
    push = pu; pop = po; cond = cd;
    src = wr ? wd : (fw ? af : m_psr);
    cond_q.push_back(ref_cond(cd, src));
    pr = 1'b0;
    nxt = src;
    if (rst) begin
      m_psr = 5'b0; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      pr = pu & po;
      if (pu && !po) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(m_psr);
        else m_ovf = 1'b1;
      end
      if (po && !pu) begin
        if (m_stk.size() > 0) nxt = m_stk.pop_back();
        else m_unf = 1'b1;
      end
      m_psr = nxt;
    end
    cnt = m_stk.size();
    state_q.push_back({m_psr, CW'(cnt), cnt == DEPTH, cnt == 0, m_ovf, m_unf, pr});
    @(negedge clk);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    stim_t s[$];
    logic ec;
    logic [12:0] es;
    s.push_back(st(1, 0, 5'h00, 0, 5'h00, 0, 0, 4'he));
    s.push_back(st(1, 1, 5'h1f, 1, 5'h1f, 1, 1, 4'he));
    foreach (s[i]) begin
      apply(s[i]);
      ec = cond_q.pop_front(); n_checks++;
      if (cond_true !== ec) begin n_fail++; $display("FAIL reset[%0d] cond_true got %b want %b", i, cond_true, ec); end
      tick();
      es = state_q.pop_front(); n_checks++;
      if (obs !== es) begin n_fail++; $display("FAIL reset[%0d] state got %h want %h", i, obs, es); end
    end
    n_checks++;
    if (obs !== {5'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL reset_const state got %h want %h", obs, {5'b0, 3'd0, 5'b01000});
    end
  endtask

  task automatic test_bypass();
    stim_t s[$];
    logic ec;
    logic [12:0] es;
    s.push_back(st(0, 1, 5'b01000, 0, 5'h00, 0, 0, 4'h0));  // EQ on ALU flags this cycle
    s.push_back(st(0, 0, 5'h00, 0, 5'h00, 0, 0, 4'h1));     // NE on registered Z=1
    s.push_back(st(0, 1, 5'b01000, 1, 5'b00000, 0, 0, 4'h0)); // psr_wr wins over flag_we
    s.push_back(st(0, 1, 5'b00001, 0, 5'h00, 0, 0, 4'h2));
    foreach (s[i]) begin
      apply(s[i]);
      ec = cond_q.pop_front(); n_checks++;
      if (cond_true !== ec) begin n_fail++; $display("FAIL bypass[%0d] cond_true got %b want %b", i, cond_true, ec); end
      tick();
      es = state_q.pop_front(); n_checks++;
      if (obs !== es) begin n_fail++; $display("FAIL bypass[%0d] state got %h want %h", i, obs, es); end
    end
    n_checks++;
    if (psr !== 5'b00001) begin n_fail++; $display("FAIL bypass_psr got %b want 00001", psr); end
  endtask

  task automatic test_push_pop();
    stim_t s[$];
    logic ec;
    logic [12:0] es;
    s.push_back(st(1, 0, 5'h00, 0, 5'h00, 0, 0, 4'he));
    s.push_back(st(0, 0, 5'h00, 1, 5'b00001, 0, 0, 4'he));
    s.push_back(st(0, 0, 5'h00, 1, 5'b10000, 1, 0, 4'h0));
    s.push_back(st(0, 0, 5'h00, 0, 5'h00, 0, 1, 4'h6));  // GT sees psr N=1, not the popped value
    s.push_back(st(0, 0, 5'h00, 0, 5'h00, 0, 0, 4'h2));
    foreach (s[i]) begin
      apply(s[i]);
      ec = cond_q.pop_front(); n_checks++;
      if (cond_true !== ec) begin n_fail++; $display("FAIL push_pop[%0d] cond_true got %b want %b", i, cond_true, ec); end
      tick();
      es = state_q.pop_front(); n_checks++;
      if (obs !== es) begin n_fail++; $display("FAIL push_pop[%0d] state got %h want %h", i, obs, es); end
    end
  endtask

  task automatic test_overflow_underflow();
    stim_t s[$];
    logic ec;
    logic [12:0] es;
    s.push_back(st(1, 0, 5'h00, 0, 5'h00, 0, 0, 4'he));
    s.push_back(st(0, 0, 5'h00, 1, 5'd1, 0, 0, 4'hf));
    for (int k = 2; k <= 6; k++) s.push_back(st(0, 0, 5'h00, 1, 5'(k), 1, 0, 4'(k)));
    for (int k = 0; k < 5; k++) s.push_back(st(0, 0, 5'h00, 0, 5'h00, 0, 1, 4'(k + 2)));
    s.push_back(st(0, 1, 5'b11010, 0, 5'h00, 0, 1, 4'h4));  // empty pop, flag_we still lands
    foreach (s[i]) begin
      apply(s[i]);
      ec = cond_q.pop_front(); n_checks++;
      if (cond_true !== ec) begin n_fail++; $display("FAIL ovf_unf[%0d] cond_true got %b want %b", i, cond_true, ec); end
      tick();
      es = state_q.pop_front(); n_checks++;
      if (obs !== es) begin n_fail++; $display("FAIL ovf_unf[%0d] state got %h want %h", i, obs, es); end
    end
  endtask

  task automatic test_proto();
    stim_t s[$];
    logic ec;
    logic [12:0] es;
    s.push_back(st(1, 0, 5'h00, 0, 5'h00, 0, 0, 4'he));
    s.push_back(st(0, 0, 5'h00, 1, 5'b00101, 1, 0, 4'h0));
    s.push_back(st(0, 0, 5'h00, 1, 5'b01010, 1, 0, 4'h0));
    s.push_back(st(0, 1, 5'b10011, 0, 5'h00, 1, 1, 4'h3));  // both strobes: stack frozen
    s.push_back(st(0, 0, 5'h00, 0, 5'h00, 0, 0, 4'h6));
    s.push_back(st(0, 0, 5'h00, 0, 5'h00, 0, 1, 4'h1));
    s.push_back(st(0, 0, 5'h00, 0, 5'h00, 0, 1, 4'h1));
    foreach (s[i]) begin
      apply(s[i]);
      ec = cond_q.pop_front(); n_checks++;
      if (cond_true !== ec) begin n_fail++; $display("FAIL proto[%0d] cond_true got %b want %b", i, cond_true, ec); end
      tick();
      es = state_q.pop_front(); n_checks++;
      if (obs !== es) begin n_fail++; $display("FAIL proto[%0d] state got %h want %h", i, obs, es); end
    end
  endtask

  task automatic test_cond_sweep();
    stim_t s[$];
    logic ec;
    logic [12:0] es;
    logic [4:0] pats [3] = '{5'b00000, 5'b11111, 5'b01000};
    foreach (pats[p]) begin
      s.push_back(st(0, 0, 5'h00, 1, pats[p], 0, 0, 4'he));
      for (int c = 0; c < 16; c++) s.push_back(st(0, 0, 5'h00, 0, 5'h00, 0, 0, 4'(c)));
    end
    foreach (s[i]) begin
      apply(s[i]);
      ec = cond_q.pop_front(); n_checks++;
      if (cond_true !== ec) begin n_fail++; $display("FAIL cond_sweep[%0d] cond=%h psr=%b got %b want %b", i, cond, psr, cond_true, ec); end
      tick();
      es = state_q.pop_front(); n_checks++;
      if (obs !== es) begin n_fail++; $display("FAIL cond_sweep[%0d] state got %h want %h", i, obs, es); end
    end
    // Z=1, L=0, N=0 held in psr
    cond = 4'hb; #1; n_checks++;
    if (cond_true !== 1'b1) begin n_fail++; $display("FAIL cond_hs got %b want 1", cond_true); end
    cond = 4'ha; #1; n_checks++;
    if (cond_true !== 1'b0) begin n_fail++; $display("FAIL cond_lo got %b want 0", cond_true); end
    cond = 4'hd; #1; n_checks++;
    if (cond_true !== 1'b1) begin n_fail++; $display("FAIL cond_ge got %b want 1", cond_true); end
    cond = 4'hc; #1; n_checks++;
    if (cond_true !== 1'b0) begin n_fail++; $display("FAIL cond_lt got %b want 0", cond_true); end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    logic ec;
    logic [12:0] es;
    s.push_back(st(1, 0, 5'h00, 0, 5'h00, 0, 0, 4'he));
    for (int k = 1; k <= 5; k++) s.push_back(st(0, 0, 5'h00, 1, 5'(k + 8), 1, 0, 4'h0));
    for (int k = 0; k < 4; k++) s.push_back(st(0, 0, 5'h00, 0, 5'h00, 0, 1, 4'h7));
    for (int k = 1; k <= 3; k++) s.push_back(st(0, 0, 5'h00, 1, 5'(k + 16), 1, 0, 4'h9));
    s.push_back(st(1, 1, 5'h1f, 1, 5'h1e, 1, 0, 4'he));
    s.push_back(st(0, 0, 5'h00, 0, 5'h00, 0, 0, 4'h1));
    foreach (s[i]) begin
      apply(s[i]);
      ec = cond_q.pop_front(); n_checks++;
      if (cond_true !== ec) begin n_fail++; $display("FAIL reset_mid[%0d] cond_true got %b want %b", i, cond_true, ec); end
      tick();
      es = state_q.pop_front(); n_checks++;
      if (obs !== es) begin n_fail++; $display("FAIL reset_mid[%0d] state got %h want %h", i, obs, es); end
      if (i == 12) begin
        n_checks++;
        if (ovf_err !== 1'b1 || stack_count !== 3'd3) begin
          n_fail++; $display("FAIL reset_mid_pre ovf=%b count=%0d want ovf=1 count=3", ovf_err, stack_count);
        end
      end
    end
    n_checks++;
    if (psr !== 5'b0 || stack_count !== 3'd0 || ovf_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_post psr=%b count=%0d ovf=%b want 00000/0/0", psr, stack_count, ovf_err);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flag_we = 1'b0; psr_wr = 1'b0; push = 1'b0; pop = 1'b0;
    alu_flags = 5'b0; psr_wdata = 5'b0; cond = 4'he;
    @(posedge clk);
    #1;
    test_reset();
    test_bypass();
    test_push_pop();
    test_overflow_underflow();
    test_proto();
    test_cond_sweep();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
